// File: rtl/eth_rx_frame_packer.sv
// Packs the Ethernet RX word stream into uDMA RX words and appends one status word per frame
// carrying the frame length and error/truncation flags.
module eth_rx_frame_packer #(
    parameter int unsigned MAX_BYTES = 1536,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cfg_en_i,
    input  logic [31:0]      s_axis_tdata,
    input  logic [1:0]       s_axis_byte_count,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [31:0]      data_rx_o,
    output logic [1:0]       data_rx_datasize_o,
    output logic             data_rx_valid_o,
    input  logic             data_rx_ready_i,
    output logic             evt_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DATA   = 3'd1;
    localparam logic [2:0] DROP   = 3'd2;
    localparam logic [2:0] STATUS = 3'd3;
    localparam logic [2:0] DISC   = 3'd4;

    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    logic [2:0]       state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic             err_q, err_d;
    logic             trunc_q, trunc_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_is_status_q, out_is_status_d;
    logic             evt_q, evt_d;
    logic             active_q;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        out_free;
    logic        status_done;
    logic        xfer;
    logic        accept_data;
    logic [2:0]  add;
    logic [16:0] len_sum;
    logic [15:0] len_new;

    assign out_free    = !out_valid_q || data_rx_ready_i;
    assign status_done = out_valid_q && data_rx_ready_i && out_is_status_q;

    // tready is held low until the first clock after reset release.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state_q)
            IDLE, DATA:  s_axis_tready = active_q && out_free;
            DROP, DISC:  s_axis_tready = active_q;
            default:     s_axis_tready = 1'b0;
        endcase
    end

    assign xfer    = s_axis_tvalid && s_axis_tready;
    assign add     = s_axis_tlast ? (3'(s_axis_byte_count) + 3'd1) : 3'd4;
    assign len_sum = {1'b0, len_q} + 17'(add);
    assign len_new = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        err_d           = err_q;
        trunc_d         = trunc_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        out_is_status_d = out_is_status_q;
        frame_cnt_d     = frame_cnt_q;
        drop_cnt_d      = drop_cnt_q;
        evt_d           = 1'b0;
        accept_data     = 1'b0;

        if (out_valid_q && data_rx_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (!cfg_en_i) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        if (!s_axis_tlast) begin
                            state_d = DISC;
                        end
                    end else begin
                        accept_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    accept_data = 1'b1;
                end
            end
            DROP: begin
                if (xfer) begin
                    len_d = len_new;
                    err_d = err_q | s_axis_tuser;
                    if (s_axis_tlast) begin
                        state_d = STATUS;
                    end
                end
            end
            STATUS: begin
                if (status_done) begin
                    evt_d       = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    len_d       = 16'd0;
                    err_d       = 1'b0;
                    trunc_d     = 1'b0;
                    state_d     = IDLE;
                end else if (out_free) begin
                    out_valid_d     = 1'b1;
                    out_is_status_d = 1'b1;
                    out_data_d      = {err_q, trunc_q, 14'b0, len_q};
                end
            end
            DISC: begin
                if (xfer && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_data) begin
            len_d = len_new;
            err_d = err_q | s_axis_tuser;
            if (len_new <= MAX_LEN) begin
                out_valid_d     = 1'b1;
                out_is_status_d = 1'b0;
                out_data_d      = s_axis_tdata;
                state_d         = s_axis_tlast ? STATUS : DATA;
            end else begin
                trunc_d = 1'b1;
                state_d = s_axis_tlast ? STATUS : DROP;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= IDLE;
            len_q           <= 16'd0;
            err_q           <= 1'b0;
            trunc_q         <= 1'b0;
            out_data_q      <= 32'd0;
            out_valid_q     <= 1'b0;
            out_is_status_q <= 1'b0;
            evt_q           <= 1'b0;
            active_q        <= 1'b0;
            frame_cnt_q     <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            err_q           <= err_d;
            trunc_q         <= trunc_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_is_status_q <= out_is_status_d;
            evt_q           <= evt_d;
            active_q        <= 1'b1;
            frame_cnt_q     <= frame_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign data_rx_o          = out_data_q;
    assign data_rx_datasize_o = 2'b10;
    assign data_rx_valid_o    = out_valid_q;
    assign evt_o              = evt_q;
    assign frame_cnt_o        = frame_cnt_q;
    assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: doc/eth_rx_frame_packer.md
Name: eth_rx_frame_packer

Overview:
- Single-clock stage directly downstream of the Ethernet RX AXIS buffer, on the uDMA/peripheral clock side.
- Consumes the 32-bit word stream: data, valid-byte count, tuser error flag, tlast.
- Forwards frame payload words to the uDMA RX channel and appends one status word per frame carrying length and error/truncation flags.
- Enforces a maximum frame size, discards frames while disabled, and raises an end-of-frame event.

Parameters:
- MAX_BYTES, 1536, maximum payload bytes forwarded per frame; bytes beyond this are discarded and the frame is flagged truncated. Must be a multiple of 4 and ≤ 65532.
- CNT_W, 16, width of the frame and drop counters.

Ports:
- clk_i  in  1  block clock.
- rstn_i  in  1  reset, asynchronous assert, active-low.
- cfg_en_i  in  1  receive enable; sampled only on the first word of a frame.
- s_axis_tdata  in  32  input word; first-received byte in [7:0].
- s_axis_byte_count  in  2  valid bytes minus 1; only meaningful with tlast, otherwise all 4 bytes are valid.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tuser  in  1  frame error (MAC/CRC), may be set on any word of the frame.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tready  out  1  input ready.
- data_rx_o  out  32  uDMA RX data.
- data_rx_datasize_o  out  2  constant 2'b10 (word).
- data_rx_valid_o  out  1  uDMA RX valid.
- data_rx_ready_i  in  1  uDMA RX ready.
- evt_o  out  1  one-cycle pulse when a status word is accepted by uDMA.
- frame_cnt_o  out  CNT_W  frames whose status word was delivered; wraps.
- drop_cnt_o  out  CNT_W  frames discarded because cfg_en_i was low; wraps.

Behaviour:
- Reset values: s_axis_tready=0, data_rx_valid_o=0, data_rx_o=0, evt_o=0, both counters=0. FSM goes to IDLE; length and error accumulators are cleared.
- Output is a single register stage; any in-flight word or frame is lost on reset.
- Output handshake: data_rx_valid_o stays high and data_rx_o stays stable until data_rx_ready_i. The register is "free" when empty or being consumed in the current cycle.
- Input transfer: occurs when s_axis_tvalid & s_axis_tready. Latency from input transfer to data_rx_valid_o is 1 cycle. Full throughput of 1 word/cycle while data_rx_ready_i stays high.
- s_axis_tready:
  - IDLE, DATA: equals "output register free".
  - DROP, DISC: 1.
  - STATUS: 0.
- Length: len accumulates per accepted word, +4, or +(byte_count+1) on a tlast word, saturating at 16'hFFFF. err is ORed from tuser over the frame.
- States:
  - IDLE: on the first transfer, if cfg_en_i=0, drop_cnt_o increments and the FSM goes to DISC (or stays in IDLE if that word has tlast); the word is not forwarded. Otherwise the word is processed as in DATA.
  - DATA: forward the word if the new len ≤ MAX_BYTES. If the word would exceed MAX_BYTES, do not forward it, set trunc, and go to DROP. On a tlast word, go to STATUS. Unused bytes of the final word are forwarded as received.
  - DROP: accept and discard words, still updating len and err; on tlast go to STATUS.
  - STATUS: when the output register is free, load the status word {err, trunc, 14'b0, len[15:0]}. On its uDMA acceptance: pulse evt_o, increment frame_cnt_o, clear len/err/trunc, return to IDLE.
  - DISC: accept and discard words; on tlast go to IDLE. No status word, no event.
- Boundaries:
  - A single-word frame (tlast on the first word) goes IDLE→STATUS.
  - A frame of exactly MAX_BYTES is not truncated.
  - tuser on the tlast word still sets err.
  - A cfg_en_i change mid-frame has no effect until the next frame start.
  - data_rx_ready_i held low stalls the input via tready with no data loss.

Test Plan:
- cfg_en_i=1, 3-word frame, bytes 0x01..0x0A, tlast byte_count=1 → data words 0x04030201, 0x08070605, 0x????0A09 (upper bytes as received), then status 0x0000000A; evt_o one pulse; frame_cnt_o=1.
- Same frame with tuser=1 on the last word → status 0x8000000A.
- MAX_BYTES=8, 4-word full frame → 2 data words forwarded, status 0x40000010, frame_cnt_o=1.
- cfg_en_i=0 at frame start, raised mid-frame, 3-word frame → no uDMA output, drop_cnt_o=1, evt_o stays 0, s_axis_tready stays 1.
- data_rx_ready_i toggling 1010… over back-to-back 2-word frames → all words delivered in order, data stable while stalled, 2 status words, frame_cnt_o=2.
- rstn_i asserted during DATA → outputs go immediately to reset values; the next full frame is received correctly with len starting from 0.
